// File: rtl/niosii_pio_pkg.sv
// Purpose : shared constants for the PIO input-capture block (register map, edge-type codes).
// Latency : n/a (package only).
// Backpressure: n/a.
// Optional feature macro used by the block: NIOSII_PIO_IN_IRQ_EN (irqmask register + irq output).
package niosii_pio_pkg;

    // Avalon-MM word addresses
    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_RSVD    = 2'd1;
    localparam logic [1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP = 2'd3;

    // EDGE_TYPE parameter encodings
    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

    // Per-bit edge decision from the synchronised sample and its delayed copy.
    function automatic logic edge_bit(input logic cur, input logic prv, input int etype);
        logic res;
        case (etype)
            EDGE_FALL: res = ~cur & prv;
            EDGE_ANY:  res = cur ^ prv;
            default:   res = cur & ~prv;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/niosii_pio_sync_edge.sv
// Purpose : two-flop synchroniser for in_port plus a delayed copy (prev) and edge detection.
// Latency : sync_o valid 2 clk edges after an input change; edge_o pulses between edges 2 and 3.
// Backpressure: none; free-running every clk.
// Ports: clk, reset (async active-high), in_port_i (async inputs),
//        sync_o (synchronised level), edge_o (one-cycle edge pulses, per EDGE_TYPE).
module niosii_pio_sync_edge
    import niosii_pio_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int EDGE_TYPE = EDGE_RISE
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_port_i,
    output logic [WIDTH-1:0] sync_o,
    output logic [WIDTH-1:0] edge_o
);

    logic [WIDTH-1:0] sync1_q;
    logic [WIDTH-1:0] sync2_q;
    logic [WIDTH-1:0] prev_q;
    // Tracks how far real samples have travelled down the pipeline after reset.
    // prev only holds a genuine sample once vld_q[2] is set; before that, the
    // zero left by reset would look like a rising edge on any input already high.
    logic [2:0]       vld_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
            vld_q   <= '0;
        end else begin
            sync1_q <= in_port_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            vld_q   <= {vld_q[1:0], 1'b1};
        end
    end

    always_comb begin
        edge_o = '0;
        if (vld_q[2]) begin
            for (int i = 0; i < WIDTH; i++) begin
                edge_o[i] = edge_bit(sync2_q[i], prev_q[i], EDGE_TYPE);
            end
        end
    end

    assign sync_o = sync2_q;

endmodule

// File: rtl/niosii_pio_in_capture.sv
// Purpose : Avalon-MM PIO input port with edge capture and optional level interrupt.
// Latency : data readable 2 clk edges after an in_port change, edgecapture 3, irq 4; reads are zero-wait.
// Backpressure: none; slave never stalls, writes take effect on the strobed clk edge.
// Ports: clk, reset (async active-high), address/chipselect/write_n/writedata/readdata (Avalon-MM slave),
//        in_port (async inputs), irq (registered level interrupt).
// Build option: define NIOSII_PIO_IN_IRQ_EN to include the irqmask register and irq logic;
//               otherwise irq is 0 and address 2 reads 0 / ignores writes.
module niosii_pio_in_capture
    import niosii_pio_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int EDGE_TYPE = EDGE_RISE
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    logic [WIDTH-1:0] sync_w;
    logic [WIDTH-1:0] edge_w;
    logic [WIDTH-1:0] ec_q;
    logic [WIDTH-1:0] ec_d;
    logic [WIDTH-1:0] ec_clr;
    logic [WIDTH-1:0] mask_w;
    logic             wr_en;
    // Upper writedata bits are never stored when WIDTH < 32.
    logic             unused_ok;

    assign unused_ok = &{1'b0, writedata};
    assign wr_en     = chipselect & ~write_n;

    niosii_pio_sync_edge #(
        .WIDTH     (WIDTH),
        .EDGE_TYPE (EDGE_TYPE)
    ) u_sync_edge (
        .clk       (clk),
        .reset     (reset),
        .in_port_i (in_port),
        .sync_o    (sync_w),
        .edge_o    (edge_w)
    );

    // Write-1-to-clear; a new edge on the same bit wins over the clear.
    always_comb begin
        ec_clr = '0;
        if (wr_en && (address == ADDR_EDGECAP)) begin
            ec_clr = writedata[WIDTH-1:0];
        end
        ec_d = (ec_q & ~ec_clr) | edge_w;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ec_q <= '0;
        end else begin
            ec_q <= ec_d;
        end
    end

`ifdef NIOSII_PIO_IN_IRQ_EN
    logic [WIDTH-1:0] mask_q;
    logic [WIDTH-1:0] mask_d;
    logic             irq_q;
    logic             irq_d;

    always_comb begin
        mask_d = mask_q;
        if (wr_en && (address == ADDR_IRQMASK)) begin
            mask_d = writedata[WIDTH-1:0];
        end
        irq_d = |(ec_q & mask_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mask_q <= '0;
            irq_q  <= 1'b0;
        end else begin
            mask_q <= mask_d;
            irq_q  <= irq_d;
        end
    end

    assign mask_w = mask_q;
    assign irq    = irq_q;
`else
    assign mask_w = '0;
    assign irq    = 1'b0;
`endif

    // Combinational read mux; bits above WIDTH read as zero.
    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA:    readdata[WIDTH-1:0] = sync_w;
            ADDR_IRQMASK: readdata[WIDTH-1:0] = mask_w;
            ADDR_EDGECAP: readdata[WIDTH-1:0] = ec_q;
            default:      readdata = '0;
        endcase
    end

endmodule
